icache_refill_ctrl: RTL
=======================

# icache_refill_ctrl

Miss handler and line-fill engine for the instruction cache. Detects a fetch miss, stalls the fetch unit, and reads one block-aligned line from IRAM word by word. It assembles the line in the cache's block bit order, then drives the cache write port (`cache_we`, `block_out`) for exactly one cycle. It is the writer end of the cache's `we`/`block_in` fill interface and sits between the fetch unit, the cache and IRAM.

## Interface
- `BLOCK_BITS`, default `icache_blocksize` (128): line size in bits; power of two, at least 64.
- `PC_W`, default `pc_size` (32): PC width.
- `MEM_W`, default 32: IRAM data width; fixed at 32.
- Derived constants: `BEATS = BLOCK_BITS/MEM_W` and `OFS_W = $clog2(BLOCK_BITS/8)`.
- `clk`  in  1  clock.
- `nrst`  in  1  reset; synchronous, active-low.
- `fetch_valid`  in  1  fetch unit presents a valid `pc` this cycle.
- `pc`  in  PC_W  fetch address.
- `cache_hit`  in  1  hit output of the instruction cache.
- `stall`  out  1  fetch must hold `pc`.
- `cache_we`  out  1  one-cycle line write strobe to the cache.
- `block_out`  out  [0:BLOCK_BITS-1]  assembled line to the cache.
- `mem_req`  out  1  IRAM read request.
- `mem_addr`  out  PC_W  IRAM byte address, word-aligned.
- `mem_gnt`  in  1  IRAM accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  MEM_W  read data, little-endian (byte at `mem_addr` is `[7:0]`).
- `miss_count`  out  32  number of refills started; saturates at 32'hFFFF_FFFF.

## Operation
- FSM states: IDLE, REQ, WAIT, FILL.
- **IDLE**
  - A miss is `fetch_valid & ~cache_hit`.
  - On a miss: `stall=1` combinationally in the same cycle; latch `base = {pc[PC_W-1:OFS_W], OFS_W'b0}`; clear `beat`; increment `miss_count` (saturating); go to REQ.
- **REQ**
  - Drive `mem_req=1` and `mem_addr = base + 4*beat`.
  - Hold both stable until `mem_gnt`, then go to WAIT.
- **WAIT**
  - Hold `mem_req=0`.
  - On `mem_rvalid`, write word `beat` into the line buffer.
  - If `beat == BEATS-1`, go to FILL. Otherwise increment `beat` and go to REQ.
- **FILL**
  - `cache_we=1` and `stall=0`; the cache forwards the instruction combinationally from `block_out`.
  - Go to IDLE. The miss check in IDLE is not evaluated during FILL.
- Bit order: `block_out[32k+8j+b] = word_k[8j+7-b]` for k < BEATS, j < 4, b < 8.
- One outstanding read at a time. `mem_rvalid` outside WAIT is ignored.
- `block_out` is held after FILL until the next fill overwrites it.
- `stall=1` in REQ and WAIT.
- `cache_hit` and `fetch_valid` are ignored outside IDLE. A refill always completes, even if `pc` changes.
- Reset (also mid-refill): state IDLE, `beat=0`, line buffer 0, `miss_count=0`. A late `mem_rvalid` after reset is ignored.

## Timing
- Reset values: `stall` 0 (then combinational), `cache_we` 0, `block_out` 0, `mem_req` 0, `mem_addr` 0, `miss_count` 0.
- Zero-wait IRAM (`mem_gnt` in the request cycle, `mem_rvalid` one cycle after grant):
  - each beat takes 2 cycles;
  - miss detected at cycle 0, REQ first at cycle 1, FILL at cycle 1+2·BEATS (cycle 9 for 128-bit lines);
  - IDLE at cycle 10.
- Each extra cycle of `mem_gnt` or `mem_rvalid` delay adds one cycle.
- `mem_addr` advances only after a `mem_rvalid`, never in the grant cycle.
- Back-to-back misses: after FILL there is one IDLE cycle before the next REQ.

## Structure
- Add `iram_width` to constants.sv alongside `icache_blocksize`, `pc_size` and `instr_size`.
- The FSM state enum (`refill_state_t`) goes in a shared `fetch_pkg` so the fetch unit and benches can observe it.
- A single module; no sub-module needed.

## Test plan
- Reset mid-WAIT: assert nrst=0 during beat 2 → next cycle IDLE, `mem_req=0`, `stall=0`, `miss_count=0`; stale `mem_rvalid` produces no `cache_we`.
- Basic miss, zero-wait memory: `pc=0x0000_1238`, `fetch_valid=1`, `cache_hit=0` → `mem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C; `cache_we` pulse at cycle 9; `miss_count=1`.
- Byte order: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C → `block_out[0:7]=8'h00`, `block_out[8:15]=8'h01`, `block_out[120:127]=8'h0F` (MSB-first within each byte).
- Stalled grant: hold `mem_gnt=0` for 3 cycles on beat 0 → `mem_req` and `mem_addr` stable; FILL delayed by 3 cycles; exactly one `cache_we`.
- Hit path: `cache_hit=1` with `fetch_valid=1` → `stall=0`, `mem_req` never asserted, `miss_count` unchanged.
- Spurious and saturation: `mem_rvalid` pulsed in IDLE → no state change; preload `miss_count=32'hFFFF_FFFF` via forced miss sequence → stays at all-ones after another miss.

Source files
------------

// File: rtl/constants.sv
// Shared sizing constants for the fetch path and instruction cache.
package constants_pkg;
    localparam int icache_blocksize = 128;
    localparam int pc_size          = 32;
    localparam int instr_size       = 32;
    localparam int iram_width       = 32;
endpackage

// File: rtl/fetch_pkg.sv
// Types shared by the fetch unit, the refill controller and their benches.
package fetch_pkg;
    import constants_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } refill_state_t;
endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch, reads one aligned line from IRAM
// a word at a time, and writes the assembled line into the cache for one cycle.
module icache_refill_ctrl
    import constants_pkg::*;
    import fetch_pkg::*;
#(
    parameter int BLOCK_BITS = icache_blocksize,
    parameter int PC_W       = pc_size,
    parameter int MEM_W      = iram_width
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  fetch_valid,
    input  logic [PC_W-1:0]       pc,
    input  logic                  cache_hit,
    output logic                  stall,
    output logic                  cache_we,
    output logic [0:BLOCK_BITS-1] block_out,
    output logic                  mem_req,
    output logic [PC_W-1:0]       mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [MEM_W-1:0]      mem_rdata,
    output logic [31:0]           miss_count
);
    localparam int BEATS  = BLOCK_BITS / MEM_W;
    localparam int OFS_W  = $clog2(BLOCK_BITS / 8);
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    refill_state_t           state_reg, state_next;
    logic [BEAT_W-1:0]       beat_reg, beat_next;
    logic [PC_W-1:0]         base_reg, base_next;
    logic [0:BLOCK_BITS-1]   line_reg, line_next;
    logic [31:0]             miss_count_reg, miss_count_next;
    logic [0:MEM_W-1]        word_swz;
    logic                    unused_pc_bits;

    // Offset bits of pc are dropped when forming the line base address.
    assign unused_pc_bits = ^pc[OFS_W-1:0];

    // Cache bit order: each byte lands MSB-first, bytes in address order.
    for (genvar gi = 0; gi < MEM_W; gi++) begin : g_swz
        assign word_swz[gi] = mem_rdata[(gi / 8) * 8 + 7 - (gi % 8)];
    end

    assign mem_addr   = base_reg + {{(PC_W-BEAT_W-2){1'b0}}, beat_reg, 2'b00};
    assign block_out  = line_reg;
    assign miss_count = miss_count_reg;

    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        base_next       = base_reg;
        line_next       = line_reg;
        miss_count_next = miss_count_reg;
        stall           = 1'b0;
        cache_we        = 1'b0;
        mem_req         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fetch_valid && !cache_hit) begin
                    stall      = 1'b1;
                    base_next  = {pc[PC_W-1:OFS_W], {OFS_W{1'b0}}};
                    beat_next  = '0;
                    state_next = REQ;
                    if (miss_count_reg != 32'hFFFF_FFFF) begin
                        miss_count_next = miss_count_reg + 32'd1;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    line_next[int'(beat_reg) * MEM_W +: MEM_W] = word_swz;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = FILL;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            FILL: begin
                // Fetch resumes this cycle; the cache forwards from block_out.
                cache_we   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            base_reg       <= '0;
            line_reg       <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            base_reg       <= base_next;
            line_reg       <= line_next;
            miss_count_reg <= miss_count_next;
        end
    end
endmodule
